// File: rtl/avr_spi_pkg.sv
// Shared SPI types: control register layout, divider code, master transfer FSM states.
package avr_spi_pkg;

  localparam int HALF_W = 7;

  typedef struct packed {
    logic       spie;
    logic       spe;
    logic       dord;
    logic       mstr;
    logic       cpol;
    logic       cpha;
    logic [1:0] spr;
  } spcr_t;

  typedef logic [2:0] spi_div_t;

  typedef enum logic {
    MX_IDLE,
    MX_XFER
  } mxfer_state_t;

  // Half SCK period in core clocks for {spi2x, spr}.
  function automatic logic [HALF_W-1:0] half_period(input spi_div_t d);
    logic [HALF_W-1:0] h;
    case (d)
      3'b000:  h = 7'd2;
      3'b001:  h = 7'd8;
      3'b010:  h = 7'd32;
      3'b011:  h = 7'd64;
      3'b100:  h = 7'd1;
      3'b101:  h = 7'd4;
      3'b110:  h = 7'd16;
      default: h = 7'd32;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/avr_spi_mstr_xfer_if.sv
// Register-block side of the SPI master engine: control, SPDR write and status returns.
interface avr_spi_mstr_xfer_if;
  import avr_spi_pkg::*;

  spcr_t       core_spcr;
  logic        spi2x;
  logic        spdr_we;
  logic [7:0]  spdr_wdata;
  logic        busy;
  logic [7:0]  rdata;
  logic        xfer_done;
  logic        wcol;

  modport master (
    output core_spcr, spi2x, spdr_we, spdr_wdata,
    input  busy, rdata, xfer_done, wcol
  );

  modport slave (
    input  core_spcr, spi2x, spdr_we, spdr_wdata,
    output busy, rdata, xfer_done, wcol
  );

endinterface

// File: rtl/avr_spi_mstr_clkdiv.sv
// Half-period counter: edge_tick fires every half_per cycles while run is high.
// Preloads half_per-1 while idle so the first tick lands half_per cycles after run rises.
module avr_spi_mstr_clkdiv #(
  parameter int DIVW = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [DIVW-1:0] half_per,
  output logic            edge_tick
);

  logic [DIVW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !run || cnt_q == '0) begin
      cnt_q <= half_per - DIVW'(1);
    end else begin
      cnt_q <= cnt_q - DIVW'(1);
    end
  end

  assign edge_tick = run && (cnt_q == '0);

endmodule

// File: rtl/avr_spi_mstr_xfer.sv
// Master SPI byte engine: SCK generation, MOSI shift, MISO sample; one byte takes 16*H cycles.
// No backpressure: SPDR writes during a transfer are dropped and reported on wcol.
module avr_spi_mstr_xfer
  import avr_spi_pkg::*;
#(
  parameter int DIVW = 7
) (
  input  logic               clk,
  input  logic               rst,
  avr_spi_mstr_xfer_if.slave rb,
  input  logic               miso_i,
  output logic               sck_o,
  output logic               mosi_o
);

  mxfer_state_t    state_q, state_d;
  logic [3:0]      edge_cnt_q;
  logic [7:0]      shreg_q, shreg_nx, rdata_q;
  logic [DIVW-1:0] half_per;
  logic            enable, run, edge_tick;
  logic            start, finish, collide, sample, drive;
  logic            done_q, wcol_q;
  logic            unused_spie;

  assign enable      = rb.core_spcr.spe & rb.core_spcr.mstr;
  assign half_per    = DIVW'(half_period({rb.spi2x, rb.core_spcr.spr}));
  assign run         = (state_q == MX_XFER) && enable;
  assign unused_spie = rb.core_spcr.spie;

  avr_spi_mstr_clkdiv #(.DIVW(DIVW)) u_clkdiv (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .half_per (half_per),
    .edge_tick(edge_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A write landing on the completion cycle still sees XFER, so it collides.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    collide = 1'b0;
    case (state_q)
      MX_IDLE: begin
        if (enable && rb.spdr_we) begin
          start   = 1'b1;
          state_d = MX_XFER;
        end
      end
      MX_XFER: begin
        if (!enable) begin
          state_d = MX_IDLE;
        end else begin
          collide = rb.spdr_we;
          if (edge_tick && edge_cnt_q == 4'd15) begin
            finish  = 1'b1;
            state_d = MX_IDLE;
          end
        end
      end
      default: state_d = MX_IDLE;
    endcase
  end

  // Even edge count = leading edge. cpha selects which edge samples; the other drives.
  always_comb begin
    sample   = edge_tick && (edge_cnt_q[0] == rb.core_spcr.cpha);
    drive    = edge_tick && (edge_cnt_q[0] != rb.core_spcr.cpha) && (edge_cnt_q != 4'd15);
    shreg_nx = shreg_q;
    if (sample) begin
      shreg_nx = rb.core_spcr.dord ? {miso_i, shreg_q[7:1]} : {shreg_q[6:0], miso_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= 8'h00;
      edge_cnt_q <= 4'd0;
      rdata_q    <= 8'h00;
      sck_o      <= 1'b0;
      mosi_o     <= 1'b0;
      done_q     <= 1'b0;
      wcol_q     <= 1'b0;
    end else begin
      done_q <= finish;
      wcol_q <= collide;
      if (start) begin
        shreg_q    <= rb.spdr_wdata;
        edge_cnt_q <= 4'd0;
        if (!rb.core_spcr.cpha) begin
          mosi_o <= rb.core_spcr.dord ? rb.spdr_wdata[0] : rb.spdr_wdata[7];
        end
      end else if (edge_tick) begin
        edge_cnt_q <= edge_cnt_q + 4'd1;
        shreg_q    <= shreg_nx;
        if (drive) begin
          mosi_o <= rb.core_spcr.dord ? shreg_q[0] : shreg_q[7];
        end
      end
      if (finish) begin
        rdata_q <= shreg_nx;
      end
      if (state_d == MX_IDLE) begin
        sck_o <= rb.core_spcr.cpol;
      end else if (edge_tick) begin
        sck_o <= ~sck_o;
      end
    end
  end

  assign rb.busy      = (state_q == MX_XFER);
  assign rb.rdata     = rdata_q;
  assign rb.xfer_done = done_q;
  assign rb.wcol      = wcol_q;

endmodule

// File: tb/tb_avr_spi_mstr_xfer.sv
// Directed bench for the SPI master engine with a behavioural SPI slave on sck_o/mosi_o/miso_i.
`timescale 1ns/1ps
module tb_avr_spi_mstr_xfer;
  import avr_spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic miso_i, sck_o, mosi_o;

  always #5 clk = ~clk;

  avr_spi_mstr_xfer_if bus();

  avr_spi_mstr_xfer #(.DIVW(7)) dut (
    .clk   (clk),
    .rst   (rst),
    .rb    (bus.slave),
    .miso_i(miso_i),
    .sck_o (sck_o),
    .mosi_o(mosi_o)
  );

  int checks = 0;
  int errors = 0;

  // Slave model: slv_tog counts SCK transitions since the write; bit index = slv_tog/2.
  logic       slv_loop;
  logic [7:0] slv_byte, slv_cap;
  logic       slv_bit;
  int         slv_tog;
  int         rise_cnt;
  time        t_last, t_prev;

  always_comb begin
    slv_bit = 1'b0;
    if (slv_tog >= 0 && slv_tog < 16) begin
      slv_bit = bus.core_spcr.dord ? slv_byte[slv_tog / 2] : slv_byte[7 - slv_tog / 2];
    end
  end

  assign miso_i = slv_loop ? mosi_o : slv_bit;

  always @(sck_o) begin
    if (slv_tog >= 0 && slv_tog < 16 && (slv_tog % 2) == int'(bus.core_spcr.cpha)) begin
      if (bus.core_spcr.dord) slv_cap[slv_tog / 2] = mosi_o;
      else                    slv_cap[7 - slv_tog / 2] = mosi_o;
    end
    slv_tog = slv_tog + 1;
  end

  always @(posedge sck_o) begin
    rise_cnt = rise_cnt + 1;
    t_prev   = t_last;
    t_last   = $time;
  end

  task automatic set_cfg(input logic spi2x, input logic [1:0] spr,
                         input logic cpol, input logic cpha, input logic dord);
    @(negedge clk);
    bus.core_spcr = '{spie: 1'b0, spe: 1'b1, dord: dord, mstr: 1'b1,
                      cpol: cpol, cpha: cpha, spr: spr};
    bus.spi2x = spi2x;
    repeat (2) @(negedge clk);
  endtask

  // Writes wd, optionally re-writes 8'hFF during busy cycle wr2_at, runs until 4 idle cycles.
  task automatic run_xfer(input logic [7:0] wd, input logic [7:0] sb, input int wr2_at,
                          output int bcyc, output int ndone, output int nwcol);
    int idle;
    idle = 0; bcyc = 0; ndone = 0; nwcol = 0;
    @(negedge clk);
    slv_byte = sb; slv_cap = 8'h00; slv_tog = 0; rise_cnt = 0;
    bus.spdr_we = 1'b1; bus.spdr_wdata = wd;
    @(negedge clk);
    bus.spdr_we = 1'b0;
    for (int i = 0; i < 3000 && idle < 4; i++) begin
      if (bus.busy) bcyc++; else idle++;
      if (bus.xfer_done) ndone++;
      if (bus.wcol) nwcol++;
      bus.spdr_we    = (wr2_at != 0) && (bcyc == wr2_at) && bus.busy;
      bus.spdr_wdata = 8'hFF;
      @(negedge clk);
    end
    bus.spdr_we = 1'b0;
    checks++;
    if (idle < 4) begin
      errors++;
      $display("FAIL xfer_timeout: busy still high after %0d cycles, required completion", bcyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sck_o !== 1'b0)         begin errors++; $display("FAIL reset_sck: got %b want 0", sck_o); end
    checks++; if (mosi_o !== 1'b0)        begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi_o); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.rdata !== 8'h00)    begin errors++; $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
    checks++; if (bus.xfer_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.xfer_done); end
    checks++; if (bus.wcol !== 1'b0)      begin errors++; $display("FAIL reset_wcol: got %b want 0", bus.wcol); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    int b, d, w;
    set_cfg(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    slv_loop = 1'b1;
    run_xfer(8'hA5, 8'h00, 0, b, d, w);
    slv_loop = 1'b0;
    checks++; if (rise_cnt != 8)       begin errors++; $display("FAIL lb_rises: got %0d want 8", rise_cnt); end
    checks++; if (b != 16)             begin errors++; $display("FAIL lb_busy: got %0d want 16", b); end
    checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL lb_rdata: got %h want a5", bus.rdata); end
    checks++; if (d != 1)              begin errors++; $display("FAIL lb_done: got %0d want 1", d); end
    checks++; if (w != 0)              begin errors++; $display("FAIL lb_wcol: got %0d want 0", w); end
    checks++; if (slv_cap !== 8'hA5)   begin errors++; $display("FAIL lb_mosi: got %h want a5", slv_cap); end
  endtask

  task automatic test_mode3_lsb();
    int b, d, w;
    set_cfg(1'b0, 2'b01, 1'b1, 1'b1, 1'b1);
    checks++; if (sck_o !== 1'b1) begin errors++; $display("FAIL m3_idle_sck: got %b want 1", sck_o); end
    run_xfer(8'h3C, 8'h96, 0, b, d, w);
    checks++; if (bus.rdata !== 8'h96)    begin errors++; $display("FAIL m3_rdata: got %h want 96", bus.rdata); end
    checks++; if (slv_cap !== 8'h3C)      begin errors++; $display("FAIL m3_mosi: got %h want 3c", slv_cap); end
    checks++; if (t_last - t_prev != 160) begin errors++; $display("FAIL m3_period: got %0d ns want 160", t_last - t_prev); end
    checks++; if (b != 128)               begin errors++; $display("FAIL m3_busy: got %0d want 128", b); end
    checks++; if (d != 1)                 begin errors++; $display("FAIL m3_done: got %0d want 1", d); end
    checks++; if (sck_o !== 1'b1)         begin errors++; $display("FAIL m3_end_sck: got %b want 1", sck_o); end
  endtask

  task automatic test_wcol();
    int b, d, w;
    set_cfg(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    run_xfer(8'h55, 8'hC3, 5, b, d, w);
    checks++; if (w != 1)              begin errors++; $display("FAIL wc_wcol: got %0d want 1", w); end
    checks++; if (slv_cap !== 8'h55)   begin errors++; $display("FAIL wc_mosi: got %h want 55", slv_cap); end
    checks++; if (d != 1)              begin errors++; $display("FAIL wc_done: got %0d want 1", d); end
    checks++; if (b != 16)             begin errors++; $display("FAIL wc_busy: got %0d want 16", b); end
    checks++; if (bus.rdata !== 8'hC3) begin errors++; $display("FAIL wc_rdata: got %h want c3", bus.rdata); end
  endtask

  task automatic test_back_to_back();
    int b, d, w;
    set_cfg(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    run_xfer(8'h5A, 8'h3C, 16, b, d, w);
    checks++; if (w != 1)  begin errors++; $display("FAIL b2b_wcol: got %0d want 1", w); end
    checks++; if (b != 16) begin errors++; $display("FAIL b2b_busy: got %0d want 16", b); end
    checks++; if (d != 1)  begin errors++; $display("FAIL b2b_done: got %0d want 1", d); end
    run_xfer(8'hA7, 8'h0F, 0, b, d, w);
    checks++; if (bus.rdata !== 8'h0F) begin errors++; $display("FAIL b2b_rdata2: got %h want 0f", bus.rdata); end
    checks++; if (slv_cap !== 8'hA7)   begin errors++; $display("FAIL b2b_mosi2: got %h want a7", slv_cap); end
    checks++; if (d != 1)              begin errors++; $display("FAIL b2b_done2: got %0d want 1", d); end
  endtask

  task automatic test_disable();
    int d;
    set_cfg(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    slv_byte = 8'hAA; slv_tog = 0;
    bus.spdr_we = 1'b1; bus.spdr_wdata = 8'h33;
    @(negedge clk);
    bus.spdr_we = 1'b0;
    for (int i = 0; i < 200 && slv_tog < 7; i++) @(negedge clk);
    checks++; if (slv_tog != 7) begin errors++; $display("FAIL dis_edge7: got %0d edges want 7", slv_tog); end
    bus.core_spcr.spe = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dis_busy: got %b want 0", bus.busy); end
    checks++; if (sck_o !== 1'b1)    begin errors++; $display("FAIL dis_sck: got %b want 1", sck_o); end
    d = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.xfer_done) d++;
      @(negedge clk);
    end
    checks++; if (d != 0)              begin errors++; $display("FAIL dis_done: got %0d want 0", d); end
    checks++; if (bus.rdata !== 8'h0F) begin errors++; $display("FAIL dis_rdata: got %h want 0f", bus.rdata); end
    bus.spdr_we = 1'b1; bus.spdr_wdata = 8'h77;
    @(negedge clk);
    bus.spdr_we = 1'b0;
    @(negedge clk);
    checks++; if (bus.wcol !== 1'b0) begin errors++; $display("FAIL dis_wr_wcol: got %b want 0", bus.wcol); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dis_wr_busy: got %b want 0", bus.busy); end
    bus.core_spcr.spe = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_div_sweep();
    int b, d, w;
    int exp_busy [8] = '{32, 128, 512, 1024, 16, 64, 256, 512};
    for (int k = 0; k < 8; k++) begin
      logic [2:0] c;
      c = k[2:0];
      set_cfg(c[2], c[1:0], 1'b0, 1'b0, 1'b0);
      run_xfer(8'h10 + 8'(k), 8'hE0 + 8'(k), 0, b, d, w);
      checks++;
      if (b != exp_busy[k]) begin
        errors++; $display("FAIL div_busy[%0d]: got %0d want %0d", k, b, exp_busy[k]);
      end
      checks++;
      if (bus.rdata !== 8'hE0 + 8'(k)) begin
        errors++; $display("FAIL div_rdata[%0d]: got %h want %h", k, bus.rdata, 8'hE0 + 8'(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    int b, d, w;
    set_cfg(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    slv_byte = 8'h00; slv_tog = 0;
    bus.spdr_we = 1'b1; bus.spdr_wdata = 8'hFF;
    @(negedge clk);
    bus.spdr_we = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (mosi_o !== 1'b1) begin errors++; $display("FAIL rm_pre_mosi: got %b want 1", mosi_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sck_o !== 1'b0)         begin errors++; $display("FAIL rm_sck: got %b want 0", sck_o); end
    checks++; if (mosi_o !== 1'b0)        begin errors++; $display("FAIL rm_mosi: got %b want 0", mosi_o); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
    checks++; if (bus.rdata !== 8'h00)    begin errors++; $display("FAIL rm_rdata: got %h want 00", bus.rdata); end
    checks++; if (bus.xfer_done !== 1'b0) begin errors++; $display("FAIL rm_done: got %b want 0", bus.xfer_done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_xfer(8'h81, 8'h7E, 0, b, d, w);
    checks++; if (bus.rdata !== 8'h7E) begin errors++; $display("FAIL rm_rdata2: got %h want 7e", bus.rdata); end
    checks++; if (slv_cap !== 8'h81)   begin errors++; $display("FAIL rm_mosi2: got %h want 81", slv_cap); end
    checks++; if (d != 1)              begin errors++; $display("FAIL rm_done2: got %0d want 1", d); end
    checks++; if (b != 128)            begin errors++; $display("FAIL rm_busy2: got %0d want 128", b); end
  endtask

  initial begin
    bus.core_spcr  = '0;
    bus.spi2x      = 1'b0;
    bus.spdr_we    = 1'b0;
    bus.spdr_wdata = 8'h00;
    slv_loop = 1'b0;
    slv_byte = 8'h00;
    slv_cap  = 8'h00;
    slv_tog  = 0;
    rise_cnt = 0;
    t_last   = 0;
    t_prev   = 0;
    rst      = 1'b1;

    test_reset();
    test_loopback();
    test_mode3_lsb();
    test_wcol();
    test_back_to_back();
    test_disable();
    test_div_sweep();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
